alu_mac_core: RTL and testbench



---
 rtl/alu_mac_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_mac_core.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mac_core.sv
// -----------------------------------------------------------------------------
// alu_mac_core
//
// Per-core ALU with an internal accumulator and a multiply-accumulate opcode,
// so that a dot-product row/column can be reduced inside the core.
// Multiplication uses an iterative shift-add unit, one step per enabled cycle.
// Valid/ready handshakes are used on both the operand and the result side.
// Only one operation is in flight at a time.
//
// Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 MAC, 4 ACC_CLR, 5 ACC_RD, 6/7 reserved.
//
// Build option: define ALU_SAT_EN to get saturating arithmetic.
//   - SUB with borrow yields 0.
//   - MAC clamps the accumulator and the result at 2^ACC_W-1.
//   - cout still flags the clamp.
// Without ALU_SAT_EN all arithmetic wraps modulo the result width.
//
// Ports:
//   clk         core clock, rising edge
//   rst         asynchronous active-high reset
//   enable      core enable; low stalls the FSM, multiplier and accumulator
//   in_valid    operands and opcode valid
//   in_ready    block can accept an operation (IDLE and enabled)
//   ALU_opcode  operation select
//   data_A_bus  operand A (unsigned)
//   data_B_bus  operand B (unsigned)
//   out_valid   result valid (HOLD state)
//   out_ready   downstream accepts the result
//   data_C_bus  result, ACC_W bits
//   z           result == 0
//   cout        carry / borrow / wrap (or clamp) flag
//   op_err      a reserved opcode was accepted
// -----------------------------------------------------------------------------
module alu_mac_core #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ALU_opcode,
    input  logic [DATA_W-1:0] data_A_bus,
    input  logic [DATA_W-1:0] data_B_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  data_C_bus,
    output logic              z,
    output logic              cout,
    output logic              op_err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_MAC     = 3'd3;
    localparam logic [2:0] OP_ACC_CLR = 3'd4;
    localparam logic [2:0] OP_ACC_RD  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [PROD_W-1:0] mcand_reg;   // multiplicand, shifted left each step
    logic [DATA_W-1:0] mplier_reg;  // multiplier, shifted right each step
    logic [PROD_W-1:0] prod_reg;    // partial product
    logic [CNT_W-1:0]  cnt_reg;     // shift-add step index
    logic              mac_reg;     // in-flight multiply is a MAC
    logic [ACC_W-1:0]  acc_reg;

    logic              accept;
    logic              is_mul_op;
    logic              mul_last;

    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] step_sum;
    logic [ACC_W:0]    mac_sum;
    logic              mac_wrap;
    logic [ACC_W-1:0]  mac_acc;

    logic [DATA_W:0]   add_sum;
    logic [DATA_W:0]   sub_diff;
    logic [ACC_W-1:0]  alu_res;
    logic              alu_cout;
    logic              alu_err;

    assign accept    = in_valid & in_ready;
    assign is_mul_op = (ALU_opcode == OP_MUL) | (ALU_opcode == OP_MAC);
    assign mul_last  = (cnt_reg == CNT_W'(DATA_W - 1));

    // Partial-product gate: the shifted multiplicand is added only when the
    // current multiplier LSB is set.
    generate
        for (genvar gi = 0; gi < PROD_W; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign step_sum = prod_reg + addend;

    // The final shift-add step and the accumulate share one edge, so the
    // result and the new accumulator appear together on entry to HOLD.
    assign mac_sum  = {1'b0, acc_reg} + (ACC_W + 1)'(step_sum);
    assign mac_wrap = mac_sum[ACC_W];
`ifdef ALU_SAT_EN
    assign mac_acc  = mac_wrap ? {ACC_W{1'b1}} : mac_sum[ACC_W-1:0];
`else
    assign mac_acc  = mac_sum[ACC_W-1:0];
`endif

    assign add_sum  = {1'b0, data_A_bus} + {1'b0, data_B_bus};
    assign sub_diff = {1'b0, data_A_bus} - {1'b0, data_B_bus};

    // Single-cycle results, computed straight from the operand buses and
    // registered on the accepting edge.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_err  = 1'b0;
        case (ALU_opcode)
            OP_ADD: begin
                alu_res  = ACC_W'(add_sum);
                alu_cout = add_sum[DATA_W];
            end
            OP_SUB: begin
                alu_cout = sub_diff[DATA_W];   // borrow: A < B
`ifdef ALU_SAT_EN
                alu_res  = sub_diff[DATA_W] ? '0 : ACC_W'(sub_diff[DATA_W-1:0]);
`else
                alu_res  = ACC_W'(sub_diff[DATA_W-1:0]);
`endif
            end
            OP_MUL, OP_MAC: begin
                // Produced by the multiplier later; nothing to register now.
            end
            OP_ACC_CLR: begin
                alu_res = '0;
            end
            OP_ACC_RD: begin
                alu_res = acc_reg;
            end
            default: begin
                alu_err = 1'b1;
            end
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = is_mul_op ? MUL : HOLD;
                end
            end
            MUL: begin
                if (enable && mul_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // The result handshake completes even while enable is low.
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_reg == IDLE) & enable & ~rst;
        out_valid = (state_reg == HOLD);
    end

    // Datapath, accumulator and registered result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            mac_reg    <= 1'b0;
            acc_reg    <= '0;
            data_C_bus <= '0;
            z          <= 1'b0;
            cout       <= 1'b0;
            op_err     <= 1'b0;
        end else if (accept) begin
            mcand_reg  <= PROD_W'(data_A_bus);
            mplier_reg <= data_B_bus;
            prod_reg   <= '0;
            cnt_reg    <= '0;
            mac_reg    <= (ALU_opcode == OP_MAC);
            op_err     <= alu_err;
            if (!is_mul_op) begin
                data_C_bus <= alu_res;
                z          <= (alu_res == '0);
                cout       <= alu_cout;
            end
            if (ALU_opcode == OP_ACC_CLR) begin
                acc_reg <= '0;
            end
        end else if (state_reg == MUL && enable) begin
            if (mul_last) begin
                if (mac_reg) begin
                    acc_reg    <= mac_acc;
                    data_C_bus <= mac_acc;
                    z          <= (mac_acc == '0);
                    cout       <= mac_wrap;
                end else begin
                    data_C_bus <= ACC_W'(step_sum);
                    z          <= (step_sum == '0);
                    cout       <= 1'b0;
                end
            end else begin
                prod_reg   <= step_sum;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_mac_core.sv
// -----------------------------------------------------------------------------
// tb_alu_mac_core
//
// Self-checking bench for alu_mac_core (DATA_W=16, ACC_W=40). Each accepted
// operation pushes its expected result, computed by an arithmetic reference
// model, onto a scoreboard queue; the entry is popped and compared when the
// DUT raises out_valid. Honors ALU_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_mac_core;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int MUL_LAT = DATA_W + 1;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ALU_opcode;
    logic [DATA_W-1:0] data_A_bus;
    logic [DATA_W-1:0] data_B_bus;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  data_C_bus;
    logic              z;
    logic              cout;
    logic              op_err;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             z;
        logic             cout;
        logic             err;
    } exp_t;

    exp_t sb[$];
    longint unsigned model_acc;
    int total;
    int bad;

    alu_mac_core #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALU_opcode (ALU_opcode),
        .data_A_bus (data_A_bus),
        .data_B_bus (data_B_bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .data_C_bus (data_C_bus),
        .z          (z),
        .cout       (cout),
        .op_err     (op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on 64-bit values.
    task automatic model_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, output exp_t e);
        longint unsigned d;
        longint unsigned s;
        longint unsigned modw;
        longint unsigned moda;
        modw = 64'd1 << DATA_W;
        moda = 64'd1 << ACC_W;
        d = 0;
        e.cout = 1'b0;
        e.err  = 1'b0;
        case (op)
            3'd0: begin
                d = longint'(a) + longint'(b);
                e.cout = (d >= modw);
            end
            3'd1: begin
                if (a >= b) begin
                    d = longint'(a) - longint'(b);
                end else begin
                    e.cout = 1'b1;
`ifdef ALU_SAT_EN
                    d = 0;
`else
                    d = modw + longint'(a) - longint'(b);
`endif
                end
            end
            3'd2: d = longint'(a) * longint'(b);
            3'd3: begin
                s = model_acc + longint'(a) * longint'(b);
                if (s >= moda) begin
                    e.cout = 1'b1;
`ifdef ALU_SAT_EN
                    s = moda - 1;
`else
                    s = s - moda;
`endif
                end
                model_acc = s;
                d = s;
            end
            3'd4: begin
                model_acc = 0;
                d = 0;
            end
            3'd5: d = model_acc;
            default: e.err = 1'b1;
        endcase
        e.data = ACC_W'(d);
        e.z    = (d == 0);
    endtask

    function automatic int lat_of(input logic [2:0] op);
        return (op == 3'd2 || op == 3'd3) ? MUL_LAT : 1;
    endfunction

    // One transaction: drive, accept, wait for result, compare.
    // stall_at > 0 drops enable for 3 cycles at that cycle count;
    // hold_cycles > 0 keeps out_ready low that many cycles once valid.
    task automatic do_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input int exp_lat,
                         input int stall_at, input int hold_cycles, input string name);
        exp_t e;
        exp_t got;
        int   lat;
        int   waited;
        bit   rdy_bad;
        bit   hold_bad;
        model_op(op, a, b, e);
        if (hold_cycles > 0) out_ready = 1'b0;
        @(negedge clk);
        in_valid   = 1'b1;
        ALU_opcode = op;
        data_A_bus = a;
        data_B_bus = b;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL %s accept: in_ready=%b required 1 within 100 cycles", name, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        rdy_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad = 1'b1;
            if (stall_at > 0 && lat == stall_at) enable = 1'b0;
            if (stall_at > 0 && lat == stall_at + 3) enable = 1'b1;
            @(negedge clk);
            lat++;
        end
        enable = 1'b1;
        got = sb.pop_front();
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL %s timeout: out_valid=%b required 1 within 200 cycles", name, out_valid);
            out_ready = 1'b1;
            return;
        end
        total++;
        if (lat !== exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        if (exp_lat > 1) begin
            total++;
            if (rdy_bad) begin
                bad++;
                $display("FAIL %s in_ready_busy: got 1 required 0 during multiply", name);
            end
        end
        total++;
        if (data_C_bus !== got.data) begin
            bad++;
            $display("FAIL %s data: got %0d required %0d", name, data_C_bus, got.data);
        end
        total++;
        if (z !== got.z) begin
            bad++;
            $display("FAIL %s z: got %b required %b", name, z, got.z);
        end
        total++;
        if (cout !== got.cout) begin
            bad++;
            $display("FAIL %s cout: got %b required %b", name, cout, got.cout);
        end
        total++;
        if (op_err !== got.err) begin
            bad++;
            $display("FAIL %s op_err: got %b required %b", name, op_err, got.err);
        end
        if (hold_cycles > 0) begin
            hold_bad = 1'b0;
            for (int i = 0; i < hold_cycles; i++) begin
                in_valid = 1'b1;   // tempt a second accept while holding
                @(negedge clk);
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_C_bus !== got.data
                    || z !== got.z || cout !== got.cout) hold_bad = 1'b1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            total++;
            if (hold_bad) begin
                bad++;
                $display("FAIL %s hold_stable: out_valid=%b in_ready=%b data=%0d required 1/0/%0d",
                         name, out_valid, in_ready, data_C_bus, got.data);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || data_C_bus !== got.data) begin
            bad++;
            $display("FAIL %s after_handshake: out_valid=%b data=%0d required 0/%0d",
                     name, out_valid, data_C_bus, got.data);
        end
        $display("txn %-10s op=%0d a=%0d b=%0d -> c=%0d z=%b cout=%b err=%b lat=%0d",
                 name, op, a, b, data_C_bus, z, cout, op_err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ALU_opcode = 3'd0;
        data_A_bus = '0;
        data_B_bus = '0;
        model_acc = 0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        total++;
        if (data_C_bus !== '0 || z !== 1'b0 || cout !== 1'b0 || op_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: c=%0d z=%b cout=%b err=%b required 0/0/0/0",
                     data_C_bus, z, cout, op_err);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        $display("txn reset done");
    endtask

    task automatic test_add();
        do_op(3'd0, 16'd6304, 16'd1843, 1, 0, 0, "add");
        do_op(3'd0, 16'hFFFF, 16'd1, 1, 0, 0, "add_carry");
        do_op(3'd0, 16'd0, 16'd0, 1, 0, 0, "add_zero");
    endtask

    task automatic test_sub();
        do_op(3'd1, 16'd6304, 16'd1843, 1, 0, 0, "sub");
        do_op(3'd1, 16'd45, 16'd45, 1, 0, 0, "sub_zero");
        do_op(3'd1, 16'd20, 16'd45, 1, 0, 0, "sub_borrow");
    endtask

    task automatic test_mul();
        do_op(3'd2, 16'd45, 16'd20, MUL_LAT, 0, 0, "mul");
        do_op(3'd2, 16'd45, 16'd20, MUL_LAT + 3, 5, 0, "mul_stall");
        do_op(3'd2, 16'hFFFF, 16'hFFFF, MUL_LAT, 0, 0, "mul_max");
    endtask

    task automatic test_mac();
        do_op(3'd4, 16'd0, 16'd0, 1, 0, 0, "acc_clr");
        do_op(3'd3, 16'd3, 16'd4, MUL_LAT, 0, 0, "mac1");
        do_op(3'd3, 16'd5, 16'd6, MUL_LAT, 0, 0, "mac2");
        do_op(3'd5, 16'd0, 16'd0, 1, 0, 4, "acc_rd");
    endtask

    task automatic test_reserved();
        do_op(3'd6, 16'd11, 16'd22, 1, 0, 0, "rsvd6");
        do_op(3'd7, 16'd1, 16'd2, 1, 0, 0, "rsvd7");
        do_op(3'd0, 16'd1, 16'd2, 1, 0, 0, "err_clear");
    endtask

    task automatic test_random();
        logic [2:0] op;
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 7));
            do_op(op, DATA_W'($urandom), DATA_W'($urandom), lat_of(op), 0, 0, "rand");
        end
    endtask

    // Accumulate the maximum product until the accumulator wraps (or clamps).
    task automatic test_mac_wrap();
        do_op(3'd4, 16'd0, 16'd0, 1, 0, 0, "acc_clr");
        for (int i = 0; i < 258; i++) begin
            do_op(3'd3, 16'hFFFF, 16'hFFFF, MUL_LAT, 0, 0, "mac_wrap");
        end
        do_op(3'd5, 16'd0, 16'd0, 1, 0, 0, "acc_rd");
    endtask

    task automatic test_reset_mid_mul();
        int waited;
        bit stale;
        @(negedge clk);
        in_valid   = 1'b1;
        ALU_opcode = 3'd3;
        data_A_bus = 16'd7;
        data_B_bus = 16'd9;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_acc = 0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || data_C_bus !== '0) begin
            bad++;
            $display("FAIL rst_mid_mul: out_valid=%b in_ready=%b data=%0d required 0/0/0",
                     out_valid, in_ready, data_C_bus);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL rst_stale: out_valid=1 required 0 after reset");
        end
        $display("txn reset mid-MAC done");
        do_op(3'd5, 16'd0, 16'd0, 1, 0, 0, "acc_rd_rst");
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_mac();
        test_reserved();
        test_random();
        test_mac();
        test_mac_wrap();
        test_mac();
        test_reset_mid_mul();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
